pll_reconfig_seq: RTL



---
 rtl/pll_reconf_pkg.sv | 49 ++++
 rtl/pll_lock_sync.sv | 28 ++
 rtl/pll_reconfig_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/pll_reconf_pkg.sv
// pll_reconf_pkg: register map, sequencer states and PLL profile table for pll_reconfig_seq
package pll_reconf_pkg;
  localparam int NUM_PROFILES_TBL = 2;
  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;
  // Write states are consecutive so the sequencer advances by incrementing the state.
  typedef enum logic [2:0] {IDLE, W_MODE, W_N, W_M, W_K, W_C0, W_START, WAIT_LOCK} state_t;
  typedef struct packed {
    logic [31:0] n_word;
    logic [31:0] m_word;
    logic [31:0] k_frac;
    logic [31:0] c0_word;
  } profile_t;
  // Counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd-duty, [22:18] counter index.
  function automatic logic [31:0] ctr_word(input logic [4:0] idx, input logic [7:0] hi, input logic [7:0] lo,
                                           input logic byp, input logic odd);
    return {9'd0, idx, odd, byp, hi, lo};
  endfunction
  localparam profile_t PROFILES [NUM_PROFILES_TBL] = '{
    '{n_word: ctr_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0), m_word: ctr_word(5'd0, 8'd4, 8'd4, 1'b0, 1'b0),
      k_frac: 32'h8000_0000, c0_word: ctr_word(5'd0, 8'd3, 8'd2, 1'b0, 1'b1)},
    '{n_word: ctr_word(5'd0, 8'd0, 8'd0, 1'b1, 1'b0), m_word: ctr_word(5'd0, 8'd4, 8'd4, 1'b0, 1'b0),
      k_frac: 32'h0000_0000, c0_word: ctr_word(5'd0, 8'd2, 8'd2, 1'b0, 1'b0)}
  };
  function automatic logic [5:0] wr_addr(input state_t s);
    case (s)
      W_MODE:  return ADDR_MODE;
      W_N:     return ADDR_N;
      W_M:     return ADDR_M;
      W_K:     return ADDR_K;
      W_C0:    return ADDR_C;
      W_START: return ADDR_START;
      default: return 6'h00;
    endcase
  endfunction
  function automatic logic [31:0] wr_data(input state_t s, input profile_t p);
    case (s)
      W_N:     return p.n_word;
      W_M:     return p.m_word;
      W_K:     return p.k_frac;
      W_C0:    return p.c0_word;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-FF lock synchronizer plus consecutive-lock counter
// Ports: clk, reset_n (sync, active-low), pll_locked (async in), en (count enable),
//        locked_sync (synchronized lock), lock_stable (high on the LOCK_STABLE-th consecutive locked cycle)
module pll_lock_sync #(
  parameter int LOCK_STABLE = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic en,
  output logic locked_sync,
  output logic lock_stable
);
  localparam int CW = $clog2(LOCK_STABLE + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  assign locked_sync = sync_q[1];
  assign lock_stable = en && locked_sync && cnt_q == CW'(LOCK_STABLE - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      cnt_q  <= !(en && locked_sync) ? '0 : lock_stable ? cnt_q : cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: programs a PLL profile through the reconfig controller's Avalon-MM port and waits for lock
// Ports: clk, reset_n (sync, active-low); req/req_profile request in; busy, done, err, active_profile, clk_stable status;
//        mgmt_address/mgmt_write/mgmt_writedata/mgmt_waitrequest to the reconfig IP; pll_locked async lock in.
// Optional: define PLL_RECONF_TIMEOUT_EN to abort the lock wait after TIMEOUT_CYCLES and raise err.
module pll_reconfig_seq import pll_reconf_pkg::*; #(
  parameter int NUM_PROFILES = NUM_PROFILES_TBL,
  parameter int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  parameter int LOCK_STABLE = 64
`ifdef PLL_RECONF_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic [PW-1:0] req_profile,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] active_profile,
  output logic          clk_stable,
  output logic [5:0]    mgmt_address,
  output logic          mgmt_write,
  output logic [31:0]   mgmt_writedata,
  input  logic          mgmt_waitrequest,
  input  logic          pll_locked
);
  state_t state_q, state_d;
  logic [PW-1:0] prof_q, prof_d, active_q, active_d, pend_p_q, pend_p_d;
  logic pend_v_q, pend_v_d, done_q, done_d, err_q, err_d;
  logic mgmt_write_q;
  logic [5:0] mgmt_address_q;
  logic [31:0] mgmt_writedata_q;
  logic locked_sync, lock_stable, timeout, wr_ok;
  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .en(state_q == WAIT_LOCK),
    .locked_sync(locked_sync), .lock_stable(lock_stable)
  );
`ifdef PLL_RECONF_TIMEOUT_EN
  logic [20:0] to_q;
  assign timeout = state_q == WAIT_LOCK && to_q == 21'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset_n || state_q != WAIT_LOCK) to_q <= '0;
    else if (!timeout) to_q <= to_q + 21'd1;
  end
`else
  assign timeout = 1'b0;
`endif
  assign wr_ok          = mgmt_write_q & ~mgmt_waitrequest;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign err            = err_q;
  assign active_profile = active_q;
  assign clk_stable     = ~busy & locked_sync;
  assign mgmt_write     = mgmt_write_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;
  // A request that cannot be taken now (busy, or the done cycle) parks in the one-deep slot.
  always_comb begin
    state_d  = state_q;
    prof_d   = prof_q;
    active_d = active_q;
    pend_v_d = pend_v_q;
    pend_p_d = pend_p_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (req && (state_q != IDLE || done_q)) begin
      pend_v_d = 1'b1;
      pend_p_d = req_profile;
    end
    case (state_q)
      IDLE: if (!done_q && (req || pend_v_q)) begin
        prof_d   = req ? req_profile : pend_p_q;
        pend_v_d = 1'b0;
        err_d    = 1'b0;
        if (prof_d == active_q && locked_sync) done_d = 1'b1;
        else state_d = W_MODE;
      end
      WAIT_LOCK: if (lock_stable) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        active_d = prof_q;
      end else if (timeout) begin
        state_d  = IDLE;
        err_d    = 1'b1;
        pend_v_d = 1'b0;
      end
      default: if (wr_ok) state_d = state_t'(state_q + 3'd1);
    endcase
  end
  // Bus outputs are derived from the next state, so they appear on the first cycle of each write state
  // and hold while stalled because the state does not move.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      prof_q           <= '0;
      active_q         <= '0;
      pend_v_q         <= 1'b0;
      pend_p_q         <= '0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= '0;
      mgmt_writedata_q <= '0;
    end else begin
      state_q          <= state_d;
      prof_q           <= prof_d;
      active_q         <= active_d;
      pend_v_q         <= pend_v_d;
      pend_p_q         <= pend_p_d;
      done_q           <= done_d;
      err_q            <= err_d;
      mgmt_write_q     <= state_d != IDLE && state_d != WAIT_LOCK;
      mgmt_address_q   <= wr_addr(state_d);
      mgmt_writedata_q <= wr_data(state_d, PROFILES[prof_d]);
    end
  end
endmodule
